// File: rtl/mix_columns_iter_if.sv
// mix_columns_iter_if: valid/ready stream bundle around the MixColumns stage; INV_MIXCOL_EN adds the inv select
interface mix_columns_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef INV_MIXCOL_EN
  logic         inv;
  modport master(output in_valid, in_data, inv, out_ready, input in_ready, out_valid, out_data);
  modport slave(input in_valid, in_data, inv, out_ready, output in_ready, out_valid, out_data);
`else
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative AES MixColumns, COLS_PER_CYCLE columns per clock; INV_MIXCOL_EN adds InvMixColumns
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input logic               clk,
  input logic               rst_n,
  mix_columns_iter_if.slave bus
);
  localparam int N = 4 / COLS_PER_CYCLE;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t       state_q;
  logic [1:0]   cnt_q;
  logic [127:0] w_q, w_d;
  logic         out_valid_q, rdy_q, last, accept;
`ifdef INV_MIXCOL_EN
  logic         inv_q;
`endif
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  // One output byte from a column rotated so that this row's own byte is on top.
  function automatic logic [7:0] frow(input logic [31:0] w);
    return xt(w[31:24]) ^ xt(w[23:16]) ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction
  function automatic logic [31:0] fmix(input logic [31:0] c);
    return {frow(c), frow({c[23:0], c[31:24]}), frow({c[15:0], c[31:16]}), frow({c[7:0], c[31:8]})};
  endfunction
`ifdef INV_MIXCOL_EN
  // k only takes 09/0B/0D/0E, built from the x, 2x, 4x, 8x partial products.
  function automatic logic [7:0] mul(input logic [7:0] x, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(x);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? x : 8'h00);
  endfunction
  function automatic logic [7:0] irow(input logic [31:0] w);
    return mul(w[31:24], 4'he) ^ mul(w[23:16], 4'hb) ^ mul(w[15:8], 4'hd) ^ mul(w[7:0], 4'h9);
  endfunction
  function automatic logic [31:0] imix(input logic [31:0] c);
    return {irow(c), irow({c[23:0], c[31:24]}), irow({c[15:0], c[31:16]}), irow({c[7:0], c[31:8]})};
  endfunction
`endif
  // Each column is rewritten only during the cycle its group number matches the counter.
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [31:0] a, m;
    assign a = w_q[127-32*c -: 32];
`ifdef INV_MIXCOL_EN
    assign m = inv_q ? imix(a) : fmix(a);
`else
    assign m = fmix(a);
`endif
    assign w_d[127-32*c -: 32] = (cnt_q == 2'(c / COLS_PER_CYCLE)) ? m : a;
  end
  assign last          = cnt_q == 2'(N - 1);
  assign bus.in_ready  = rdy_q & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = w_q;
  // Control FSM: load on accept, mix one column group per cycle, then hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      w_q         <= '0;
      out_valid_q <= 1'b0;
      rdy_q       <= 1'b0;
`ifdef INV_MIXCOL_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      rdy_q <= 1'b1;
      if (accept) begin
        w_q <= bus.in_data;
`ifdef INV_MIXCOL_EN
        inv_q <= bus.inv;
`endif
      end
      case (state_q)
        IDLE: state_q <= accept ? BUSY : IDLE;
        BUSY: begin
          w_q         <= w_d;
          cnt_q       <= last ? 2'd0 : cnt_q + 2'd1;
          state_q     <= last ? DONE : BUSY;
          out_valid_q <= last;
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= accept ? BUSY : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mix_columns_iter.sv
// tb_mix_columns_iter: scoreboard bench for mix_columns_iter at COLS_PER_CYCLE 1/2/4; INV_MIXCOL_EN adds inverse tests
module tb_mix_columns_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic [127:0] exp_q[$];
  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  mix_columns_iter_if if1();
  mix_columns_iter_if if2();
  mix_columns_iter_if if4();
  mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic iv);
    logic [31:0] co;
    logic [127:0] o;
    logic [7:0] acc;
    co = iv ? 32'h0e0b0d09 : 32'h02030101;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc ^= gmul(8'(s >> (120 - 32*c - 8*k)), 8'(co >> (24 - 8*((k - r + 4) % 4))));
        o |= 128'(acc) << (120 - 32*c - 8*r);
      end
    return o;
  endfunction

  task automatic set_inv(input logic v);
`ifdef INV_MIXCOL_EN
    if1.inv = v;
`else
    if (v) $display("note: inverse mode not built, block runs forward");
`endif
  endtask

  task automatic run_one(input logic [127:0] d, input logic iv, output logic [127:0] got, output int lat);
    @(posedge clk); #1;
    if1.in_valid = 1'b1;
    if1.in_data = d;
    set_inv(iv);
    if1.out_ready = 1'b1;
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    if1.in_data = ~d;
    lat = -1;
    got = '0;
    for (int cyc = 1; cyc <= 20 && lat < 0; cyc++) begin
      @(posedge clk); #1;
      if (if1.out_valid) begin lat = cyc; got = if1.out_data; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    checks += 3;
    if (if1.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", if1.in_ready); end
    if (if1.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", if1.out_valid); end
    if (if1.out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", if1.out_data); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (if1.in_ready !== 1'b0) begin failures++; $display("FAIL release_in_ready_pre_clk got=%b exp=0", if1.in_ready); end
    @(negedge clk);
    checks++;
    if (if1.in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", if1.in_ready); end
  endtask

  task automatic test_fips;
    int lat[3];
    logic [127:0] got[3];
    lat = '{0, 0, 0};
    got = '{'0, '0, '0};
    @(posedge clk); #1;
    if1.in_valid = 1'b1; if2.in_valid = 1'b1; if4.in_valid = 1'b1;
    if1.in_data = FIPS_IN; if2.in_data = FIPS_IN; if4.in_data = FIPS_IN;
    if1.out_ready = 1'b1; if2.out_ready = 1'b1; if4.out_ready = 1'b1;
    set_inv(1'b0);
    @(posedge clk); #1;
    if1.in_valid = 1'b0; if2.in_valid = 1'b0; if4.in_valid = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      if (if1.out_valid && lat[0] == 0) begin lat[0] = cyc; got[0] = if1.out_data; end
      if (if2.out_valid && lat[1] == 0) begin lat[1] = cyc; got[1] = if2.out_data; end
      if (if4.out_valid && lat[2] == 0) begin lat[2] = cyc; got[2] = if4.out_data; end
    end
    checks += 6;
    if (lat[0] !== 4) begin failures++; $display("FAIL fips_latency_cpc1 got=%0d exp=4", lat[0]); end
    if (lat[1] !== 2) begin failures++; $display("FAIL fips_latency_cpc2 got=%0d exp=2", lat[1]); end
    if (lat[2] !== 1) begin failures++; $display("FAIL fips_latency_cpc4 got=%0d exp=1", lat[2]); end
    if (got[0] !== FIPS_OUT) begin failures++; $display("FAIL fips_data_cpc1 got=%h exp=%h", got[0], FIPS_OUT); end
    if (got[1] !== FIPS_OUT) begin failures++; $display("FAIL fips_data_cpc2 got=%h exp=%h", got[1], FIPS_OUT); end
    if (got[2] !== FIPS_OUT) begin failures++; $display("FAIL fips_data_cpc4 got=%h exp=%h", got[2], FIPS_OUT); end
  endtask

  task automatic test_columns;
    logic [127:0] got;
    int lat;
    run_one(128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, got, lat);
    checks += 2;
    if (lat !== 4) begin failures++; $display("FAIL columns_latency got=%0d exp=4", lat); end
    if (got !== 128'h8e4da1bc9fdc589d01010101c6c6c6c6) begin
      failures++; $display("FAIL columns_data got=%h exp=8e4da1bc9fdc589d01010101c6c6c6c6", got);
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] a, b;
    int lat;
    a = 128'h00112233445566778899aabbccddeeff;
    b = 128'h0123456789abcdeffedcba9876543210;
    @(posedge clk); #1;
    if1.in_valid = 1'b1; if1.in_data = a; set_inv(1'b0); if1.out_ready = 1'b0;
    @(posedge clk); #1;
    if1.in_valid = 1'b0; if1.in_data = ~a;
    lat = -1;
    for (int cyc = 1; cyc <= 20 && lat < 0; cyc++) begin
      @(posedge clk); #1;
      if (if1.out_valid) lat = cyc;
    end
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks += 3;
      if (if1.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, if1.out_valid); end
      if (if1.out_data !== model(a, 1'b0)) begin failures++; $display("FAIL bp_hold_data cyc=%0d got=%h exp=%h", i, if1.out_data, model(a, 1'b0)); end
      if (if1.in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_in_ready cyc=%0d got=%b exp=0", i, if1.in_ready); end
    end
    if1.out_ready = 1'b1; if1.in_valid = 1'b1; if1.in_data = b;
    #1;
    checks++;
    if (if1.in_ready !== 1'b1) begin failures++; $display("FAIL bp_same_cycle_ready got=%b exp=1", if1.in_ready); end
    @(posedge clk); #1;
    if1.in_valid = 1'b0; if1.in_data = ~b;
    checks++;
    if (if1.out_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_drop got=%b exp=0", if1.out_valid); end
    lat = -1;
    for (int cyc = 1; cyc <= 20 && lat < 0; cyc++) begin
      @(posedge clk); #1;
      if (if1.out_valid) lat = cyc;
    end
    checks += 2;
    if (lat !== 4) begin failures++; $display("FAIL bp_next_latency got=%0d exp=4", lat); end
    if (if1.out_data !== model(b, 1'b0)) begin failures++; $display("FAIL bp_next_data got=%h exp=%h", if1.out_data, model(b, 1'b0)); end
    @(posedge clk); #1;
    checks++;
    if (if1.out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%b exp=0", if1.out_valid); end
  endtask

  task automatic test_reset_mid;
    logic [127:0] got;
    int lat;
    @(posedge clk); #1;
    if1.in_valid = 1'b1; if1.in_data = {4{32'hffffffff}} ^ FIPS_OUT; set_inv(1'b0); if1.out_ready = 1'b1;
    @(posedge clk); #1;
    if1.in_valid = 1'b1; if1.in_data = FIPS_OUT;
    @(posedge clk); #1;
    checks++;
    if (if1.in_ready !== 1'b0) begin failures++; $display("FAIL busy_in_ready got=%b exp=0", if1.in_ready); end
    if1.in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (if1.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", if1.out_valid); end
    if (if1.out_data !== '0) begin failures++; $display("FAIL midrst_out_data got=%h exp=0", if1.out_data); end
    if (if1.in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready got=%b exp=0", if1.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_one(FIPS_IN, 1'b0, got, lat);
    checks += 2;
    if (lat !== 4) begin failures++; $display("FAIL midrst_next_latency got=%0d exp=4", lat); end
    if (got !== FIPS_OUT) begin failures++; $display("FAIL midrst_next_data got=%h exp=%h", got, FIPS_OUT); end
  endtask

`ifdef INV_MIXCOL_EN
  task automatic test_inv;
    logic [127:0] got, x, y;
    int lat;
    run_one(FIPS_OUT, 1'b1, got, lat);
    checks += 2;
    if (lat !== 4) begin failures++; $display("FAIL inv_latency got=%0d exp=4", lat); end
    if (got !== FIPS_IN) begin failures++; $display("FAIL inv_data got=%h exp=%h", got, FIPS_IN); end
    x = 128'h00112233445566778899aabbccddeeff;
    y = FIPS_OUT;
    @(posedge clk); #1;
    if1.in_valid = 1'b1; if1.in_data = x; if1.inv = 1'b0; if1.out_ready = 1'b1;
    @(posedge clk); #1;
    if1.in_data = y; if1.inv = 1'b1;
    lat = -1;
    for (int cyc = 1; cyc <= 20 && lat < 0; cyc++) begin
      @(posedge clk); #1;
      if (if1.out_valid) lat = cyc;
    end
    checks++;
    if (if1.out_data !== model(x, 1'b0)) begin failures++; $display("FAIL b2b_fwd_data got=%h exp=%h", if1.out_data, model(x, 1'b0)); end
    @(posedge clk); #1;
    if1.in_valid = 1'b0; if1.inv = 1'b0;
    lat = -1;
    for (int cyc = 1; cyc <= 20 && lat < 0; cyc++) begin
      @(posedge clk); #1;
      if (if1.out_valid) lat = cyc;
    end
    checks += 2;
    if (lat !== 4) begin failures++; $display("FAIL b2b_inv_latency got=%0d exp=4", lat); end
    if (if1.out_data !== FIPS_IN) begin failures++; $display("FAIL b2b_inv_data got=%h exp=%h", if1.out_data, FIPS_IN); end
  endtask
`endif

  task automatic test_stream(input int n, input int pv, input int pr);
    int sent, recv, cyc, last_out;
    logic acc;
    logic iv;
    logic [127:0] d, e;
    sent = 0; recv = 0; cyc = 0; last_out = -1; acc = 1'b0; iv = 1'b0; d = '0;
    exp_q.delete();
    while (recv < n && cyc < n * 30) begin
      @(posedge clk); #1;
      cyc++;
      if (acc) if1.in_valid = 1'b0;
      acc = 1'b0;
      if (!if1.in_valid && sent < n && $urandom_range(99) < pv) begin
        d = {$urandom, $urandom, $urandom, $urandom};
`ifdef INV_MIXCOL_EN
        iv = 1'($urandom_range(1));
`endif
        if1.in_data = d;
        set_inv(iv);
        if1.in_valid = 1'b1;
      end
      if1.out_ready = $urandom_range(99) < pr;
      @(negedge clk);
      if (if1.in_valid && if1.in_ready) begin
        exp_q.push_back(model(d, iv));
        sent++;
        acc = 1'b1;
      end
      if (if1.out_valid && if1.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL stream_extra_output got=%h exp=none", if1.out_data);
        end else begin
          e = exp_q.pop_front();
          if (if1.out_data !== e) begin failures++; $display("FAIL stream_data blk=%0d got=%h exp=%h", recv, if1.out_data, e); end
        end
        if (pv == 100 && pr == 100 && last_out >= 0) begin
          checks++;
          if (cyc - last_out !== 5) begin failures++; $display("FAIL stream_spacing blk=%0d got=%0d exp=5", recv, cyc - last_out); end
        end
        last_out = cyc;
        recv++;
      end
    end
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    checks += 2;
    if (recv !== n) begin failures++; $display("FAIL stream_count got=%0d exp=%0d", recv, n); end
    if (exp_q.size() !== 0) begin failures++; $display("FAIL stream_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    if1.in_valid = 1'b0; if1.in_data = '0; if1.out_ready = 1'b0;
    if2.in_valid = 1'b0; if2.in_data = '0; if2.out_ready = 1'b1;
    if4.in_valid = 1'b0; if4.in_data = '0; if4.out_ready = 1'b1;
`ifdef INV_MIXCOL_EN
    if1.inv = 1'b0; if2.inv = 1'b0; if4.inv = 1'b0;
`endif
    test_reset;
    test_fips;
    test_columns;
    test_backpressure;
    test_reset_mid;
`ifdef INV_MIXCOL_EN
    test_inv;
`endif
    test_stream(8, 100, 100);
    test_stream(1000, 60, 60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
